// File: rtl/sample_iter_ctrl_if.sv
// sample_iter_ctrl_if: triangle-in / sample-out bundle for the sample iterator.
interface sample_iter_ctrl_if #(
   parameter int SIGFIG = 24,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
);
   logic signed [SIGFIG-1:0] tri_R13S    [VERTS][AXIS];
   logic        [SIGFIG-1:0] color_R13U  [COLORS];
   logic signed [SIGFIG-1:0] box_R13S    [2][2];
   logic                     validTri_R13H;
   logic        [3:0]        subSample_RnnU;
   logic                     stall_R14H;
   logic                     halt_RnnH;
   logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS];
   logic        [SIGFIG-1:0] color_R14U  [COLORS];
   logic signed [SIGFIG-1:0] sample_R14S [2];
   logic                     validSamp_R14H;

   modport master (
      output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnU, stall_R14H,
      input  halt_RnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
   );

   modport slave (
      input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnU, stall_R14H,
      output halt_RnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
   );
endinterface

// File: rtl/sample_iter_ctrl.sv
// sample_iter_ctrl: walks a triangle's bounding box in raster order, one sample per unstalled cycle.
module sample_iter_ctrl #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
) (
   input logic clk,
   input logic rst,
   sample_iter_ctrl_if.slave bus
);
   typedef enum logic {WAIT, TEST} state_e;

   localparam logic [SIGFIG-1:0] ONE = SIGFIG'(1);

   state_e                   state_q, state_d;
   logic signed [SIGFIG-1:0] tri_q   [VERTS][AXIS];
   logic signed [SIGFIG-1:0] tri_d   [VERTS][AXIS];
   logic        [SIGFIG-1:0] color_q [COLORS];
   logic        [SIGFIG-1:0] color_d [COLORS];
   logic signed [SIGFIG-1:0] llx_q, llx_d, lly_q, lly_d, urx_q, urx_d, ury_q, ury_d;
   logic signed [SIGFIG-1:0] x_q, x_d, y_q, y_d;
   logic        [SIGFIG-1:0] step_q, step_d, step_sel;
   logic signed [SIGFIG:0]   nx, ny;
   logic                     legal, x_over, y_over;

   always_comb begin
      step_sel = (bus.subSample_RnnU == 4'b0100) ? ONE << (RADIX - 1) :
                 (bus.subSample_RnnU == 4'b0010) ? ONE << (RADIX - 2) :
                 (bus.subSample_RnnU == 4'b0001) ? ONE << (RADIX - 3) : ONE << RADIX;
      legal    = (bus.box_R13S[1][0] >= bus.box_R13S[0][0]) && (bus.box_R13S[1][1] >= bus.box_R13S[0][1]);
      // One extra bit keeps x+step from wrapping negative near the top of the signed range
      nx       = {x_q[SIGFIG-1], x_q} + {1'b0, step_q};
      ny       = {y_q[SIGFIG-1], y_q} + {1'b0, step_q};
      x_over   = nx > $signed({urx_q[SIGFIG-1], urx_q});
      y_over   = ny > $signed({ury_q[SIGFIG-1], ury_q});
      state_d  = state_q;
      tri_d    = tri_q;
      color_d  = color_q;
      llx_d    = llx_q;
      lly_d    = lly_q;
      urx_d    = urx_q;
      ury_d    = ury_q;
      step_d   = step_q;
      x_d      = x_q;
      y_d      = y_q;
      if (state_q == WAIT && bus.validTri_R13H && legal) begin
         state_d = TEST;
         tri_d   = bus.tri_R13S;
         color_d = bus.color_R13U;
         llx_d   = bus.box_R13S[0][0];
         lly_d   = bus.box_R13S[0][1];
         urx_d   = bus.box_R13S[1][0];
         ury_d   = bus.box_R13S[1][1];
         step_d  = step_sel;
         x_d     = bus.box_R13S[0][0];
         y_d     = bus.box_R13S[0][1];
      end else if (state_q == TEST && !bus.stall_R14H) begin
         state_d = (x_over && y_over) ? WAIT : TEST;
         x_d     = x_over ? llx_q : nx[SIGFIG-1:0];
         y_d     = (x_over && !y_over) ? ny[SIGFIG-1:0] : y_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= WAIT;
         tri_q   <= '{default: '0};
         color_q <= '{default: '0};
         llx_q   <= '0;
         lly_q   <= '0;
         urx_q   <= '0;
         ury_q   <= '0;
         step_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         tri_q   <= tri_d;
         color_q <= color_d;
         llx_q   <= llx_d;
         lly_q   <= lly_d;
         urx_q   <= urx_d;
         ury_q   <= ury_d;
         step_q  <= step_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   assign bus.halt_RnnH      = state_q == TEST;
   assign bus.validSamp_R14H = state_q == TEST;
   assign bus.sample_R14S[0] = x_q;
   assign bus.sample_R14S[1] = y_q;
   assign bus.tri_R14S       = tri_q;
   assign bus.color_R14U     = color_q;
endmodule

// File: tb/tb_sample_iter_ctrl.sv
// tb_sample_iter_ctrl: vector table plus reset sequence, with a sample scoreboard fed by a raster model.
module tb_sample_iter_ctrl;
   localparam int SIGFIG = 24;
   localparam int RADIX  = 10;

   typedef struct {
      int         llx, lly, urx, ury;
      logic [3:0] sub;
      int         stall_idx;
      int         n_exp;
   } vec_t;

   typedef struct {
      int x, y;
   } samp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0, fails = 0;
   int   halt_cycles = 0, accepted = 0, stall_cnt = 0;
   samp_t q[$];
   logic signed [SIGFIG-1:0] exp_tri   [3][3];
   logic        [SIGFIG-1:0] exp_color [3];
   vec_t vecs [10];

   sample_iter_ctrl_if #(.SIGFIG(SIGFIG)) bus ();

   sample_iter_ctrl #(.SIGFIG(SIGFIG), .RADIX(RADIX)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int step_of(logic [3:0] sub);
      return (sub == 4'b0100) ? 512 : (sub == 4'b0010) ? 256 : (sub == 4'b0001) ? 128 : 1024;
   endfunction

   task automatic push_model(vec_t v);
      int st = step_of(v.sub);
      if (v.urx < v.llx || v.ury < v.lly) return;
      for (int y = v.lly; y <= v.ury; y += st)
         for (int x = v.llx; x <= v.urx; x += st)
            q.push_back('{x, y});
   endtask

   task automatic drive_tri(vec_t v, int idx);
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            bus.tri_R13S[i][j] = SIGFIG'(idx * 100 + i * 10 + j + 1);
            exp_tri[i][j]      = SIGFIG'(idx * 100 + i * 10 + j + 1);
         end
         bus.color_R13U[i] = SIGFIG'(idx * 7 + i + 3);
         exp_color[i]      = SIGFIG'(idx * 7 + i + 3);
      end
      bus.box_R13S[0][0]  = SIGFIG'(v.llx);
      bus.box_R13S[0][1]  = SIGFIG'(v.lly);
      bus.box_R13S[1][0]  = SIGFIG'(v.urx);
      bus.box_R13S[1][1]  = SIGFIG'(v.ury);
      bus.subSample_RnnU  = v.sub;
      bus.validTri_R13H   = 1'b1;
      halt_cycles = 0;
      accepted    = 0;
      stall_cnt   = 0;
      push_model(v);
   endtask

   task automatic run_vec(vec_t v, int idx);
      @(negedge clk);
      drive_tri(v, idx);
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         bus.validTri_R13H = 1'b0;
         bus.stall_R14H = bus.validSamp_R14H && accepted == v.stall_idx && stall_cnt < 3;
         if (bus.stall_R14H) stall_cnt++;
         if (q.size() == 0 && !bus.halt_RnnH) break;
      end
      bus.stall_R14H = 1'b0;
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_count", idx), accepted, v.n_exp);
      check($sformatf("v%0d_halt_cycles", idx), halt_cycles, v.n_exp + (v.stall_idx >= 0 ? 3 : 0));
      check($sformatf("v%0d_left_in_queue", idx), q.size(), 0);
      q.delete();
   endtask

   // Scoreboard: every valid cycle must match the queue head; only unstalled cycles consume it
   always begin
      @(negedge clk);
      #1;
      if (bus.halt_RnnH) halt_cycles++;
      if (bus.validSamp_R14H) begin
         if (q.size() == 0) check("spurious_sample", 1, 0);
         else begin
            bit ok = 1'b1;
            check("sample_x", int'(bus.sample_R14S[0]), q[0].x);
            check("sample_y", int'(bus.sample_R14S[1]), q[0].y);
            for (int i = 0; i < 3; i++) begin
               for (int j = 0; j < 3; j++) if (bus.tri_R14S[i][j] != exp_tri[i][j]) ok = 1'b0;
               if (bus.color_R14U[i] != exp_color[i]) ok = 1'b0;
            end
            check("tri_color_hold", int'(ok), 1);
            if (!bus.stall_R14H) begin
               void'(q.pop_front());
               accepted++;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected to finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0, 0, 1024, 1024, 4'b1000, -1, 4};
      vecs[1] = '{0, 0, 1024, 1024, 4'b0100, -1, 9};
      vecs[2] = '{2048, 3072, 2048, 3072, 4'b1000, -1, 1};
      vecs[3] = '{0, 0, 1024, 1024, 4'b1000, 1, 4};
      vecs[4] = '{1024, 0, 0, 0, 4'b1000, -1, 0};
      vecs[5] = '{0, 0, 1024, 1024, 4'b0011, -1, 4};
      vecs[6] = '{0, 0, 255, 127, 4'b0001, -1, 2};
      vecs[7] = '{0, 0, 1024, 0, 4'b0010, -1, 5};
      vecs[8] = '{8387584, 8387584, 8388607, 8388607, 4'b1000, -1, 1};
      vecs[9] = '{-2048, -1024, -1024, 0, 4'b1000, -1, 4};
      bus.tri_R13S       = '{default: '0};
      bus.color_R13U     = '{default: '0};
      bus.box_R13S       = '{default: '0};
      bus.validTri_R13H  = 1'b0;
      bus.subSample_RnnU = 4'b1000;
      bus.stall_R14H     = 1'b0;
      exp_tri            = '{default: '0};
      exp_color          = '{default: '0};
      repeat (2) @(negedge clk);
      #1;
      check("rst_halt", int'(bus.halt_RnnH), 0);
      check("rst_valid", int'(bus.validSamp_R14H), 0);
      check("rst_sample_x", int'(bus.sample_R14S[0]), 0);
      check("rst_sample_y", int'(bus.sample_R14S[1]), 0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Reset while the second sample is presented, then a fresh triangle
      @(negedge clk);
      drive_tri(vecs[0], 20);
      @(negedge clk);
      bus.validTri_R13H = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #2;
      check("midrst_accepted_before", accepted, 1);
      check("midrst_halt", int'(bus.halt_RnnH), 0);
      check("midrst_valid", int'(bus.validSamp_R14H), 0);
      check("midrst_sample_x", int'(bus.sample_R14S[0]), 0);
      check("midrst_tri", int'(bus.tri_R14S[2][2]), 0);
      check("midrst_color", int'(bus.color_R14U[1]), 0);
      q.delete();
      exp_tri   = '{default: '0};
      exp_color = '{default: '0};
      repeat (2) @(negedge clk);
      rst = 1'b1;
      halt_cycles = 0;
      repeat (4) @(negedge clk);
      check("postrst_idle_halt_cycles", halt_cycles, 0);
      run_vec('{4096, 1024, 5120, 1024, 4'b1000, -1, 2}, 21);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sample_iter_ctrl.md
SAMPLE_ITER_CTRL -- requirements
Module: sample_iter_ctrl

Interface
REQ-001 SHALL have parameter SIGFIG, default 24, bits in position and color words.
REQ-002 SHALL have parameter RADIX, default 10, fraction bits in position words.
REQ-003 SHALL have parameter VERTS, default 3, vertices per triangle.
REQ-004 SHALL have parameter AXIS, default 3, axes per vertex (x,y,z).
REQ-005 SHALL have parameter COLORS, default 3, color channels.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port tri_R13S, input, signed [SIGFIG-1:0] x [VERTS][AXIS], incoming triangle.
REQ-009 SHALL have port color_R13U, input, unsigned [SIGFIG-1:0] x [COLORS], triangle color.
REQ-010 SHALL have port box_R13S, input, signed [SIGFIG-1:0] x [2][2], bounding box: [0]=lower-left (x,y), [1]=upper-right (x,y).
REQ-011 SHALL have port validTri_R13H, input, 1, triangle and box valid this cycle.
REQ-012 SHALL have port subSample_RnnU, input, 4, one-hot sample step select.
REQ-013 SHALL have port stall_R14H, input, 1, downstream cannot accept a sample this cycle.
REQ-014 SHALL have port halt_RnnH, output, 1, high = not accepting a triangle.
REQ-015 SHALL have port tri_R14S, output, same shape as tri_R13S, triangle being iterated.
REQ-016 SHALL have port color_R14U, output, same shape as color_R13U.
REQ-017 SHALL have port sample_R14S, output, signed [SIGFIG-1:0] x [2], current sample (x,y).
REQ-018 SHALL have port validSamp_R14H, output, 1, sample_R14S valid.

Function
REQ-019 SHALL implement two states: WAIT (idle) and TEST (iterating).
REQ-020 SHALL drive halt_RnnH high exactly when state is TEST.
REQ-021 In WAIT with validTri_R13H=1 and a legal box, SHALL capture tri, color, box and step; next cycle state=TEST, sample_R14S=lower-left, validSamp_R14H=1.
REQ-022 Legal box: UR.x >= LL.x and UR.y >= LL.y; otherwise SHALL drop the triangle, stay in WAIT, emit no sample.
REQ-023 Step SHALL be latched at capture: 4'b1000 -> 2^RADIX, 4'b0100 -> 2^(RADIX-1), 4'b0010 -> 2^(RADIX-2), 4'b0001 -> 2^(RADIX-3); any non-one-hot value -> 2^RADIX.
REQ-024 In TEST with stall_R14H=1, SHALL hold every output and all internal state unchanged.
REQ-025 In TEST with stall_R14H=0, SHALL advance raster order once per cycle: x += step; if x+step > UR.x then x = LL.x and y += step.
REQ-026 Last sample: x+step > UR.x and y+step > UR.y; when issued unstalled, next cycle SHALL be WAIT with validSamp_R14H=0 and halt_RnnH=0.
REQ-027 All next-position additions and comparisons SHALL use SIGFIG+1 signed bits so that no wrap-around occurs near the box edge or the maximum positive value.
REQ-028 Degenerate box (LL==UR) SHALL produce exactly one sample.
REQ-029 Upper-right bounds SHALL be inclusive: a sample with x==UR.x or y==UR.y is issued.
REQ-030 validTri_R13H while in TEST SHALL be ignored (upstream is responsible for holding it while halt_RnnH=1).
REQ-031 tri_R14S and color_R14U SHALL remain constant for the whole TEST period.

Reset
REQ-032 On rst=0, asynchronously: state=WAIT, validSamp_R14H=0, halt_RnnH=0, sample_R14S, tri_R14S, color_R14U all zero.
REQ-033 Reset asserted mid-TEST SHALL abandon the triangle; after release, no residual sample is issued and the next validTri is accepted.

Verification
REQ-034 RADIX=10, box LL(0,0) UR(1024,1024), subSample 4'b1000, no stall -> samples (0,0),(1024,0),(0,1024),(1024,1024) on 4 consecutive cycles; cycle 5: validSamp=0, halt=0.
REQ-035 Same box, subSample 4'b0100 -> 9 samples, step 512, row order x=0,512,1024 for each y=0,512,1024.
REQ-036 Box LL(2048,3072)=UR -> single sample (2048,3072); halt high for exactly 1 cycle.
REQ-037 REQ-034 case with stall_R14H=1 for 3 cycles while sample (1024,0) is presented -> (1024,0) held 4 cycles; total sequence unchanged.
REQ-038 Box LL(1024,0) UR(0,0) -> no validSamp, halt stays 0; rst=0 during the 2nd sample of REQ-034 -> outputs zero immediately; a new triangle after release starts at its lower-left.
